// File: rtl/operand_loader_if.sv
// Execute-stage handshake bundle for operand_loader.
// master: opcode/ea/operand/page_cross/op_valid out, op_ack in.
interface operand_loader_if #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
);
    logic [REG_WIDTH-1:0]  opcode_out;
    logic [ADDR_WIDTH-1:0] ea_out;
    logic [REG_WIDTH-1:0]  operand_out;
    logic                  page_cross;
    logic                  op_valid;
    logic                  op_ack;

    modport master (
        output opcode_out,
        output ea_out,
        output operand_out,
        output page_cross,
        output op_valid,
        input  op_ack
    );

    modport slave (
        input  opcode_out,
        input  ea_out,
        input  operand_out,
        input  page_cross,
        input  op_valid,
        output op_ack
    );
endinterface

// File: rtl/operand_loader.sv
// Operand loader: captures a fetched instruction, performs pointer and
// operand reads, and presents opcode/ea/operand to execute.
// Ports: clk, reset (sync, active-high); fetch side instr_valid,
// instr_in, ea_in, y_in; memory mem_addr, mem_rd, mem_rdata;
// status busy, overrun; op_if (master) carries the execute handshake.
// Optional macro OPLOAD_SKID_EN adds a one-entry skid for edges
// arriving while busy.
module operand_loader #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    input  logic [REG_WIDTH-1:0]  instr_in,
    input  logic [ADDR_WIDTH-1:0] ea_in,
    input  logic [REG_WIDTH-1:0]  y_in,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  busy,
    output logic                  overrun,
    operand_loader_if.master      op_if
);

    localparam int PAD = ADDR_WIDTH - REG_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_PTR_LO, S_PTR_HI, S_EA, S_RD, S_WAIT, S_HOLD
    } state_e;

    typedef enum logic [2:0] {
        M_X_IND = 3'b000, M_ZPG, M_IMM, M_ABS,
        M_IND_Y, M_ZPG_X, M_ABS_Y, M_ABS_X
    } mode_e;

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    logic                  iv_q, iv_d;
    logic [REG_WIDTH-1:0]  opcode_q, opcode_d;
    logic [REG_WIDTH-1:0]  ptr_q, ptr_d;
    logic [REG_WIDTH-1:0]  lo_q, lo_d;
    logic [ADDR_WIDTH-1:0] ea_q, ea_d;
    logic [REG_WIDTH-1:0]  operand_q, operand_d;
    logic                  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic                  ovr_q, ovr_d;

`ifdef OPLOAD_SKID_EN
    logic                  skv_q, skv_d;
    logic [REG_WIDTH-1:0]  skins_q, skins_d;
    logic [ADDR_WIDTH-1:0] skea_q, skea_d;
`endif

    logic                  cap_edge;
    logic                  cap_go;
    logic [REG_WIDTH-1:0]  cap_instr;
    logic [ADDR_WIDTH-1:0] cap_ea;
    mode_e                 cap_mode;
    logic [REG_WIDTH:0]    lo_sum;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        iv_d      = instr_valid;
        opcode_d  = opcode_q;
        ptr_d     = ptr_q;
        lo_d      = lo_q;
        ea_d      = ea_q;
        operand_d = operand_q;
        pc_d      = pc_q;
        ovr_d     = ovr_q;
        mem_rd    = 1'b0;
        maddr_d   = maddr_q;
        cap_edge  = instr_valid & ~iv_q;
        cap_go    = 1'b0;
        cap_instr = instr_in;
        cap_ea    = ea_in;
        lo_sum    = {1'b0, lo_q} + {1'b0, y_in};
`ifdef OPLOAD_SKID_EN
        skv_d     = skv_q;
        skins_d   = skins_q;
        skea_d    = skea_q;
`endif

        // Select the capture source and track edges lost while busy.
        if (state_q == S_IDLE) begin
`ifdef OPLOAD_SKID_EN
            if (skv_q) begin
                cap_go    = 1'b1;
                cap_instr = skins_q;
                cap_ea    = skea_q;
                skv_d     = cap_edge;
                if (cap_edge) begin
                    skins_d = instr_in;
                    skea_d  = ea_in;
                end
            end else begin
                cap_go = cap_edge;
            end
`else
            cap_go = cap_edge;
`endif
        end else if (cap_edge) begin
`ifdef OPLOAD_SKID_EN
            if (!skv_q) begin
                skv_d   = 1'b1;
                skins_d = instr_in;
                skea_d  = ea_in;
            end else begin
                ovr_d = 1'b1;
            end
`else
            ovr_d = 1'b1;
`endif
        end

        cap_mode = mode_e'(cap_instr[4:2]);

        case (state_q)
            S_IDLE: begin
                if (cap_go) begin
                    opcode_d = cap_instr;
                    mode_d   = cap_mode;
                    pc_d     = 1'b0;
                    unique case (cap_mode)
                        M_IMM: begin
                            operand_d = cap_ea[REG_WIDTH-1:0];
                            ea_d      = cap_ea;
                            state_d   = S_HOLD;
                        end
                        M_X_IND, M_IND_Y: begin
                            ptr_d   = cap_ea[REG_WIDTH-1:0];
                            state_d = S_PTR_LO;
                        end
                        default: begin
                            ea_d    = cap_ea;
                            state_d = S_RD;
                        end
                    endcase
                end
            end
            S_PTR_LO: begin
                mem_rd  = 1'b1;
                maddr_d = {{PAD{1'b0}}, ptr_q};
                state_d = S_PTR_HI;
            end
            S_PTR_HI: begin
                lo_d    = mem_rdata;
                mem_rd  = 1'b1;
                // Pointer high byte stays in page zero.
                maddr_d = {{PAD{1'b0}}, ptr_q + REG_WIDTH'(1)};
                state_d = S_EA;
            end
            S_EA: begin
                if (mode_q == M_IND_Y) begin
                    ea_d = ADDR_WIDTH'({mem_rdata, lo_q})
                         + ADDR_WIDTH'(y_in);
                    pc_d = lo_sum[REG_WIDTH];
                end else begin
                    ea_d = ADDR_WIDTH'({mem_rdata, lo_q});
                end
                state_d = S_RD;
            end
            S_RD: begin
                mem_rd  = 1'b1;
                maddr_d = ea_q;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                operand_d = mem_rdata;
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                if (op_if.op_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mode_q    <= M_X_IND;
            iv_q      <= 1'b1;
            opcode_q  <= '0;
            ptr_q     <= '0;
            lo_q      <= '0;
            ea_q      <= '0;
            operand_q <= '0;
            pc_q      <= 1'b0;
            maddr_q   <= '0;
            ovr_q     <= 1'b0;
`ifdef OPLOAD_SKID_EN
            skv_q     <= 1'b0;
            skins_q   <= '0;
            skea_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            iv_q      <= iv_d;
            opcode_q  <= opcode_d;
            ptr_q     <= ptr_d;
            lo_q      <= lo_d;
            ea_q      <= ea_d;
            operand_q <= operand_d;
            pc_q      <= pc_d;
            maddr_q   <= maddr_d;
            ovr_q     <= ovr_d;
`ifdef OPLOAD_SKID_EN
            skv_q     <= skv_d;
            skins_q   <= skins_d;
            skea_q    <= skea_d;
`endif
        end
    end

    assign mem_addr          = maddr_d;
    assign busy              = (state_q != S_IDLE);
    assign overrun           = ovr_q;
    assign op_if.opcode_out  = opcode_q;
    assign op_if.ea_out      = ea_q;
    assign op_if.operand_out = operand_q;
    assign op_if.page_cross  = pc_q;
    assign op_if.op_valid    = (state_q == S_HOLD);

endmodule
